mem_responder: RTL and testbench

Memory-side responder for the multicycle core's fetch/load/store request handshake. The control unit initiates a request; this block completes it.
- Serves instruction fetches during FETCH and data accesses during EXECUTE/WRITE_BACK.
- Holds word storage and returns data after a programmable number of wait states, with done/error signalling.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_array.sv | 45 ++++
 rtl/mem_responder.sv | 177 +++++++++++++++++
 tb/tb_mem_responder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the memory request/response handshake. The
// responder and the control unit's initiator side both import this package
// so that the state encoding and field widths stay in step.
//
// Contents:
//   WORD_W   - data word width (bits)
//   BE_W     - number of byte lanes in a word
//   OFFS_W   - byte-offset bits below the word index in a byte address
//   state_e  - responder FSM state encoding
//
// Optional feature macro used by the files importing this package:
//   MEM_BYTE_WRITE_EN - adds per-byte write enables to stores.
package mem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = WORD_W / 8;
    localparam int OFFS_W = $clog2(BE_W);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/mem_array.sv
// mem_array
// Synchronous single-port word storage. Writes happen on the rising clock
// edge for the byte lanes whose enable is set; the read port is
// combinational so the responder can register the word on the same edge it
// issues the access. Contents are deliberately not reset.
//
// Ports:
//   clk_i    in   rising-edge clock
//   we_i     in   write strobe for this cycle
//   idx_i    in   word index
//   wdata_i  in   write data
//   be_i     in   byte-lane enables (all ones for full-word writes)
//   rdata_o  out  word currently stored at idx_i
//
// Configuration macro: MEM_BYTE_WRITE_EN (the array itself always honours
// be_i; the responder ties it high when the macro is undefined).
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  logic [WORD_W-1:0]        wdata_i,
    input  logic [BE_W-1:0]          be_i,
    output logic [WORD_W-1:0]        rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Byte-lane write; lanes with a cleared enable keep their old contents.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mem_responder.sv
// mem_responder
// Memory-side responder for the multicycle core's fetch/load/store
// handshake. A request is accepted in IDLE, waits WAIT_CYCLES cycles, and
// is completed with a single-cycle ack in RESP. Misaligned or out-of-range
// addresses complete with err=1, no write, and rdata forced to 0.
//
// Ports:
//   clk_i    in   rising-edge clock
//   rst_ni   in   asynchronous active-low reset
//   req_i    in   request valid, held until ack
//   we_i     in   1 = store, 0 = load/fetch
//   addr_i   in   byte address
//   wdata_i  in   store data
//   be_i     in   byte enables (only with MEM_BYTE_WRITE_EN)
//   ack_o    out  one-cycle completion pulse
//   rdata_o  out  load data, held until the next ack
//   err_o    out  qualifies ack: misaligned or out-of-range access
//   busy_o   out  high from acceptance through the ack cycle
//
// Configuration macro: MEM_BYTE_WRITE_EN adds be_i and byte-masked stores.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
`ifdef MEM_BYTE_WRITE_EN
    input  logic [BE_W-1:0]   be_i,
`endif
    output logic              ack_o,
    output logic [WORD_W-1:0] rdata_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              ack_q;
    logic              err_q;
    logic              busy_q;
    logic [WORD_W-1:0] rdata_q;

    logic              op_we;
    logic [ADDR_W-1:0] op_addr;
    logic [WORD_W-1:0] op_wdata;
    logic [BE_W-1:0]   op_be;
    logic              op_err;
    logic              enter_resp;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;

    // With zero wait states the access is issued on the accept edge itself,
    // so in IDLE the operation comes straight from the inputs; afterwards it
    // comes from the latched copy, which makes later input changes harmless.
    assign op_we    = (state_q == IDLE) ? we_i    : we_q;
    assign op_addr  = (state_q == IDLE) ? addr_i  : addr_q;
    assign op_wdata = (state_q == IDLE) ? wdata_i : wdata_q;

`ifdef MEM_BYTE_WRITE_EN
    logic [BE_W-1:0] be_q;
    assign op_be = (state_q == IDLE) ? be_i : be_q;
`else
    assign op_be = '1;
`endif

    // Anything above the top word of storage, or not word aligned, is an error.
    assign op_err = (op_addr[OFFS_W-1:0] != '0) ||
                    (op_addr[ADDR_W-1:IDX_W+OFFS_W] != '0);

    // The edge that moves the FSM into RESP is the one that performs the access.
    assign enter_resp = ((state_q == IDLE) && req_i && (WAIT_CYCLES == 0)) ||
                        ((state_q == WAIT) && (cnt_q == CNT_LAST));

    assign mem_we = enter_resp && op_we && !op_err;
    assign cnt_d  = cnt_q - CNT_LAST;

    mem_array #(
        .DEPTH (DEPTH)
    ) u_mem_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .idx_i   (op_addr[IDX_W+OFFS_W-1:OFFS_W]),
        .wdata_i (op_wdata),
        .be_i    (op_be),
        .rdata_o (mem_rdata)
    );

    // Responder FSM with registered outputs. ack/err default low so they
    // pulse for exactly the RESP cycle; a reset at any point drops back to
    // IDLE without an ack and without touching storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef MEM_BYTE_WRITE_EN
            be_q    <= '0;
`endif
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
`ifdef MEM_BYTE_WRITE_EN
                        be_q    <= be_i;
`endif
                        busy_q  <= 1'b1;
                        cnt_q   <= CNT_LOAD;
                        state_q <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase

            // Stores leave rdata alone; errors force it to zero.
            if (enter_resp) begin
                ack_q <= 1'b1;
                err_q <= op_err;
                if (op_err) begin
                    rdata_q <= '0;
                end else if (!op_we) begin
                    rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign busy_o  = busy_q;
    assign rdata_o = rdata_q;

    // The initiator must keep req high while the access is in flight.
    reqHeldUntilAck: assert property (
        @(posedge clk_i) disable iff (!rst_ni) (state_q == WAIT) |-> req_i
    );

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
// Drives two responders side by side (WAIT_CYCLES=2 and WAIT_CYCLES=0, both
// with 16 words) and checks them against a word-array model that applies
// the access rules directly: error when the address is not a multiple of 4
// or lies at/after 4*DEPTH, loads return the stored word, stores update it.
module tb_mem_responder;

    localparam int DEPTH = 16;
    localparam int W0    = 2;
    localparam int W1    = 0;
    localparam int LIMIT = 20;
`ifdef MEM_BYTE_WRITE_EN
    localparam bit BE_ON = 1'b1;
`else
    localparam bit BE_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];
    logic        ack   [2];
    logic        err   [2];
    logic        busy  [2];
    logic [31:0] rdata [2];

    logic [31:0] model     [2][DEPTH];
    logic [31:0] lastRdata [2];
    bit          holdValid [2];
    int          total;
    int          bad;

    mem_responder #(.DEPTH(DEPTH), .ADDR_W(32), .WAIT_CYCLES(W0)) dut0 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .req_i   (req[0]),
        .we_i    (we[0]),
        .addr_i  (addr[0]),
        .wdata_i (wdata[0]),
`ifdef MEM_BYTE_WRITE_EN
        .be_i    (be[0]),
`endif
        .ack_o   (ack[0]),
        .rdata_o (rdata[0]),
        .err_o   (err[0]),
        .busy_o  (busy[0])
    );

    mem_responder #(.DEPTH(DEPTH), .ADDR_W(32), .WAIT_CYCLES(W1)) dut1 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .req_i   (req[1]),
        .we_i    (we[1]),
        .addr_i  (addr[1]),
        .wdata_i (wdata[1]),
`ifdef MEM_BYTE_WRITE_EN
        .be_i    (be[1]),
`endif
        .ack_o   (ack[1]),
        .rdata_o (rdata[1]),
        .err_o   (err[1]),
        .busy_o  (busy[1])
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and counts and reports a failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic int waitOf(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    function automatic bit isErr(input logic [31:0] a);
        return ((a % 4) != 0) || (a >= 4 * DEPTH);
    endfunction

    // Byte lanes with enable set take the new value; without byte enables
    // every store replaces the whole word.
    function automatic logic [31:0] mergeBytes(input logic [31:0] oldW,
                                               input logic [31:0] newW,
                                               input logic [3:0]  en);
        logic [31:0] res;
        logic [3:0]  effEn;
        effEn = BE_ON ? en : 4'hF;
        res   = oldW;
        for (int i = 0; i < 4; i++) begin
            if (effEn[i]) res[8*i +: 8] = newW[8*i +: 8];
        end
        return res;
    endfunction

    // Quiet-cycle checks: no ack, no err, not busy, rdata still held.
    task automatic checkIdle(input int d, input string tag);
        checkOutput({tag, "_ack"}, 32'(ack[d]), 32'd0);
        checkOutput({tag, "_err"}, 32'(err[d]), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy[d]), 32'd0);
        if (holdValid[d]) checkOutput({tag, "_rdataHold"}, rdata[d], lastRdata[d]);
    endtask

    // One complete transaction. Called #1 after a rising edge with the DUT
    // idle; returns #1 after the edge following the ack, DUT idle again.
    // After the accept edge the request fields are disturbed to prove the
    // latched copy is what gets used.
    task automatic applyStimulus(input int d, input logic w, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [3:0] bein);
        bit          expErr;
        logic [31:0] expRd;
        int          cycles;
        bit          seen;
        expErr = isErr(a);
        expRd  = expErr ? 32'd0 : model[d][a / 4];
        we[d]    = w;
        addr[d]  = a;
        wdata[d] = wd;
        be[d]    = bein;
        req[d]   = 1'b1;
        cycles   = 0;
        seen     = 1'b0;
        while (!seen && cycles < LIMIT) begin
            @(posedge clk);
            #1;
            cycles++;
            if (ack[d]) begin
                seen = 1'b1;
            end else begin
                checkOutput("waitBusy", 32'(busy[d]), 32'd1);
                checkOutput("waitErr", 32'(err[d]), 32'd0);
                we[d]    = ~w;
                addr[d]  = a ^ 32'h4;
                wdata[d] = $urandom;
                be[d]    = ~bein;
            end
        end
        checkOutput("ackLatency", 32'(cycles), 32'(waitOf(d) + 1));
        if (seen) begin
            checkOutput("respErr", 32'(err[d]), 32'(expErr));
            checkOutput("respBusy", 32'(busy[d]), 32'd1);
            if (expErr || !w) begin
                checkOutput("respRdata", rdata[d], expRd);
                lastRdata[d] = expRd;
                holdValid[d] = 1'b1;
            end else begin
                holdValid[d] = 1'b0;
            end
        end
        if (w && !expErr) model[d][a / 4] = mergeBytes(model[d][a / 4], wd, bein);
        req[d] = 1'b0;
        @(posedge clk);
        #1;
        checkIdle(d, "afterAck");
    endtask

    function automatic logic [31:0] randAddr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)       return 32'($urandom_range(0, DEPTH - 1) * 4);
        else if (r == 7) return 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        else if (r == 8) return 32'(4 * DEPTH + $urandom_range(0, 63));
        else             return $urandom | 32'h8000_0000;
    endfunction

    initial begin
        logic [31:0] keep;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0; be[d] = 4'hF;
            lastRdata[d] = 32'd0;
            holdValid[d] = 1'b1;
        end

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) checkIdle(d, "reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Give every word a known value.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++)
                applyStimulus(d, 1'b1, 32'(i * 4), $urandom, 4'hF);

        // Store then load, WAIT_CYCLES=2.
        applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'hF);
        checkOutput("loadDeadbeef", rdata[0], 32'hDEADBEEF);

        // Fields change to 0x14 after accept; response must come from 0x10.
        applyStimulus(0, 1'b1, 32'h14, 32'h14141414, 4'hF);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'hF);
        checkOutput("latchedAddr", rdata[0], 32'hDEADBEEF);

        // Back-to-back loads with req held high, WAIT_CYCLES=0.
        we[1] = 1'b0; addr[1] = 32'h0; req[1] = 1'b1;
        @(posedge clk); #1;
        checkOutput("b2bAck0", 32'(ack[1]), 32'd1);
        checkOutput("b2bBusy0", 32'(busy[1]), 32'd1);
        checkOutput("b2bRdata0", rdata[1], model[1][0]);
        addr[1] = 32'h4;
        @(posedge clk); #1;
        checkOutput("b2bGapAck", 32'(ack[1]), 32'd0);
        checkOutput("b2bGapBusy", 32'(busy[1]), 32'd0);
        @(posedge clk); #1;
        checkOutput("b2bAck1", 32'(ack[1]), 32'd1);
        checkOutput("b2bBusy1", 32'(busy[1]), 32'd1);
        checkOutput("b2bRdata1", rdata[1], model[1][1]);
        lastRdata[1] = model[1][1];
        holdValid[1] = 1'b1;
        req[1] = 1'b0;
        @(posedge clk); #1;
        checkIdle(1, "b2bEnd");

        // Misaligned load and out-of-range store.
        applyStimulus(0, 1'b0, 32'h6, 32'h0, 4'hF);
        checkOutput("misalignRdata", rdata[0], 32'h0);
        keep = model[0][0];
        applyStimulus(0, 1'b1, 32'(4 * DEPTH), 32'hCAFEF00D, 4'hF);
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'hF);
        checkOutput("oorNoWrite", rdata[0], keep);

        // Reset in WAIT during a store: no ack, no write.
        keep = model[0][8];
        we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h12345678; be[0] = 4'hF; req[0] = 1'b1;
        @(posedge clk); #1;
        checkOutput("midBusy", 32'(busy[0]), 32'd1);
        checkOutput("midAck", 32'(ack[0]), 32'd0);
        rst_n = 1'b0;
        req[0] = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            lastRdata[d] = 32'd0;
            holdValid[d] = 1'b1;
        end
        checkIdle(0, "midReset");
        @(posedge clk); #1;
        checkIdle(0, "inReset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkIdle(0, "postReset");
        applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'hF);
        checkOutput("resetNoWrite", rdata[0], keep);

`ifdef MEM_BYTE_WRITE_EN
        // Byte-masked stores.
        applyStimulus(0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'hF);
        applyStimulus(0, 1'b1, 32'h8, 32'h000000AA, 4'b0001);
        applyStimulus(0, 1'b0, 32'h8, 32'h0, 4'hF);
        checkOutput("beByte0", rdata[0], 32'hFFFFFFAA);
        applyStimulus(0, 1'b1, 32'h8, 32'h12345678, 4'b0000);
        applyStimulus(0, 1'b0, 32'h8, 32'h0, 4'hF);
        checkOutput("beNone", rdata[0], 32'hFFFFFFAA);
`endif

        // Random mix across both responders.
        for (int n = 0; n < 80; n++) begin
            int          d;
            logic [31:0] a;
            d = $urandom_range(0, 1);
            a = ($urandom_range(0, 3) == 0) ? 32'h8 : randAddr();
            applyStimulus(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
        end

        // Final read-back of every word against the model.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++)
                applyStimulus(d, 1'b0, 32'(i * 4), 32'h0, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
